// File: rtl/genie_credit_sender.sv
// genie_credit_sender
// Transmit side of a credit-flow link. It accepts beats from an upstream
// valid/ready stream and forwards them as single-cycle valid pulses with no
// backpressure. One credit is spent for each beat sent. The far-end receiver
// returns one credit for each beat it drains. Ready is decoded only from the
// registered credit count, so a returned credit cannot reach o_ready in the
// same cycle. This keeps the link free of any combinational loop.
module genie_credit_sender #(
    parameter int WIDTH   = 1,
    parameter int CREDITS = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_valid,
    input  logic                         i_credit,
    output logic [$clog2(CREDITS+1)-1:0] o_credits,
    output logic                         o_err
);

    localparam int            CW          = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] MAX_CREDITS = CW'(CREDITS);
    localparam logic [CW-1:0] ONE_CREDIT  = CW'(1);

    logic [CW-1:0]    credits_q, credits_d;
    logic             valid_q,   valid_d;
    logic [WIDTH-1:0] data_q,    data_d;
    logic             err_q,     err_d;

    logic ready;
    logic send;
    logic at_max;
    logic overflow;

    // A beat is accepted whenever at least one credit remains.
    assign ready    = (credits_q != '0);
    assign send     = i_valid & ready;
    assign at_max   = (credits_q == MAX_CREDITS);
    // A credit that arrives while the count is full and nothing is being sent
    // has no outstanding beat to account for. This is a protocol error.
    assign overflow = i_credit & ~send & at_max;

    // Credit counter next state: spend on send, refund on i_credit, saturate at full.
    always_comb begin
        credits_d = credits_q;
        if (send && !i_credit) begin
            credits_d = credits_q - ONE_CREDIT;
        end else if (!send && i_credit && !at_max) begin
            credits_d = credits_q + ONE_CREDIT;
        end
    end

    // Link output next state: pulse valid one cycle after acceptance, hold data otherwise.
    always_comb begin
        valid_d = send;
        data_d  = data_q;
        if (send) begin
            data_d = i_data;
        end
    end

    // Sticky error next state: set on overflow, cleared only by reset.
    always_comb begin
        err_d = err_q | overflow;
    end

    // State registers. Reset drops any in-flight beat and refills the credits.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            credits_q <= MAX_CREDITS;
            valid_q   <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    assign o_ready   = ready;
    assign o_valid   = valid_q;
    assign o_data    = data_q;
    assign o_credits = credits_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_genie_credit_sender.sv
// Directed bench for genie_credit_sender. It includes a receiver model that
// tracks buffered beats for the credit invariant. It also uses an upstream
// scoreboard that checks link data order.
module tb_genie_credit_sender;

    localparam int WIDTH   = 8;
    localparam int CREDITS = 4;
    localparam int CW      = $clog2(CREDITS + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_credit;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [CW-1:0]    out_credits;
    logic             out_err;

    always #5 clk = ~clk;

    genie_credit_sender #(
        .WIDTH   (WIDTH),
        .CREDITS (CREDITS)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_data    (in_data),
        .i_valid   (in_valid),
        .o_ready   (out_ready),
        .o_data    (out_data),
        .o_valid   (out_valid),
        .i_credit  (in_credit),
        .o_credits (out_credits),
        .o_err     (out_err)
    );

    int checks   = 0;
    int failures = 0;

    // Receiver model: beats held at the far end whose credit has not yet been returned.
    int               rx_count    = 0;
    logic [WIDTH-1:0] exp_q[$];
    bit               inv_en      = 1'b1;
    bit               auto_credit = 1'b0;

    // Outputs sampled on the falling edge of the current cycle.
    logic             s_ready;
    logic             s_valid;
    logic             s_err;
    logic [WIDTH-1:0] s_data;
    logic [CW-1:0]    s_credits;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one clock cycle of stimulus, sample mid-cycle, and update the models.
    task automatic cycle(input logic r, input logic v, input logic [WIDTH-1:0] d, input logic c);
        logic [WIDTH-1:0] front;
        rst      = r;
        in_valid = v;
        in_data  = d;
        if (auto_credit) begin
            c = (rx_count > 0) && ($urandom_range(0, 2) == 0);
        end
        in_credit = c;
        if (c && rx_count > 0) begin
            rx_count--;
        end
        @(negedge clk);
        s_ready   = out_ready;
        s_valid   = out_valid;
        s_data    = out_data;
        s_credits = out_credits;
        s_err     = out_err;
        check_eq("ready_decode", 32'(s_ready), 32'(s_credits != '0));
        if (inv_en) begin
            check_eq("credit_invariant",
                     32'(int'(s_credits) + int'(s_valid) + rx_count + int'(c)), 32'(CREDITS));
        end
        if (s_valid) begin
            check_eq("rx_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                front = exp_q.pop_front();
                check_eq("rx_data", 32'(s_data), 32'(front));
            end
        end
        if (!r && v && s_ready) begin
            exp_q.push_back(d);
        end
        @(posedge clk);
        #1;
        if (r) begin
            rx_count = 0;
            exp_q.delete();
        end else if (s_valid) begin
            rx_count++;
        end
    endtask

    // Return credits at random until every beat has been drained.
    task automatic drain(input string tag);
        auto_credit = 1'b1;
        for (int i = 0; i < 80; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b0);
            if (s_credits == CW'(CREDITS) && rx_count == 0 && !s_valid) break;
        end
        auto_credit = 1'b0;
        check_eq(tag, 32'(s_credits), 32'(CREDITS));
    endtask

    initial begin
        int pulses;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_credit = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Test 1: reset state.
        @(negedge clk);
        check_eq("t1_credits", 32'(out_credits), 32'(CREDITS));
        check_eq("t1_ready",   32'(out_ready),   32'd1);
        check_eq("t1_valid",   32'(out_valid),   32'd0);
        check_eq("t1_err",     32'(out_err),     32'd0);
        check_eq("t1_data",    32'(out_data),    32'd0);
        @(posedge clk);
        #1;

        // Test 2: six offered beats with no credits returned. Only four are sent.
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, 1'b1, WIDTH'(k), 1'b0);
            check_eq("t2_credits", 32'(s_credits), 32'((k <= 5) ? 5 - k : 0));
            check_eq("t2_ready",   32'(s_ready),   32'(k <= 4));
            check_eq("t2_valid",   32'(s_valid),   32'(k >= 2 && k <= 5));
            if (k >= 2 && k <= 5) begin
                check_eq("t2_data", 32'(s_data), 32'(k - 1));
            end
            if (s_valid) pulses++;
        end
        check_eq("t2_pulses", 32'(pulses), 32'd4);

        // Test 3: one returned credit lets data 5 through on the following cycle.
        cycle(1'b0, 1'b1, WIDTH'(5), 1'b1);
        check_eq("t3_ready_same_cycle", 32'(s_ready),   32'd0);
        check_eq("t3_credits_a",        32'(s_credits), 32'd0);
        cycle(1'b0, 1'b1, WIDTH'(5), 1'b0);
        check_eq("t3_ready_next",       32'(s_ready),   32'd1);
        check_eq("t3_credits_b",        32'(s_credits), 32'd1);
        check_eq("t3_valid_b",          32'(s_valid),   32'd0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        check_eq("t3_valid_c",          32'(s_valid),   32'd1);
        check_eq("t3_data_c",           32'(s_data),    32'd5);
        check_eq("t3_credits_c",        32'(s_credits), 32'd0);

        // Test 4: continuous send with continuous credit return runs at full rate.
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b0, 1'b1, WIDTH'(8'h10 + k), 1'b1);
            if (k >= 2) check_eq("t4_credits", 32'(s_credits), 32'd1);
            if (k >= 3) check_eq("t4_valid",   32'(s_valid),   32'd1);
        end
        drain("t4_drain");

        // Test 5: a credit while full is an overflow. The count holds and the error sticks.
        inv_en = 1'b0;
        cycle(1'b0, 1'b0, '0, 1'b1);
        check_eq("t5_err_before", 32'(s_err),     32'd0);
        inv_en = 1'b1;
        cycle(1'b0, 1'b0, '0, 1'b0);
        check_eq("t5_err_set",    32'(s_err),     32'd1);
        check_eq("t5_credits",    32'(s_credits), 32'(CREDITS));
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, WIDTH'(8'h30 + k), 1'b0);
            check_eq("t5_err_sticky", 32'(s_err), 32'd1);
        end
        drain("t5_drain");

        // Test 6: reset with two beats in flight.
        cycle(1'b0, 1'b1, WIDTH'(8'h21), 1'b0);
        cycle(1'b0, 1'b1, WIDTH'(8'h22), 1'b0);
        check_eq("t6_inflight_credits", 32'(s_credits), 32'd3);
        cycle(1'b1, 1'b0, '0, 1'b0);
        check_eq("t6_pre_reset_credits", 32'(s_credits), 32'd2);
        cycle(1'b0, 1'b0, '0, 1'b0);
        check_eq("t6_credits", 32'(s_credits), 32'(CREDITS));
        check_eq("t6_valid",   32'(s_valid),   32'd0);
        check_eq("t6_err",     32'(s_err),     32'd0);
        check_eq("t6_data",    32'(s_data),    32'd0);

        // Random traffic with randomly delayed credit return.
        auto_credit = 1'b1;
        for (int k = 0; k < 200; k++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), WIDTH'($urandom), 1'b0);
        end
        auto_credit = 1'b0;
        drain("rand_drain");
        check_eq("rand_err", 32'(s_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
